// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit: access sizes, FSM states,
// byte-strobe generation and load-data extension.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DRAIN,
        ST_EXC
    } lsu_state_e;

    // Strobes for up to 8 lanes; the caller truncates to its own lane count.
    // Big-endian mirrors the pattern so offset 0 lands on the top lane.
    function automatic logic [7:0] mk_strobe(input logic [1:0] size,
                                             input logic [2:0] off,
                                             input logic       big_endian,
                                             input logic [3:0] lanes);
        logic [15:0] mask;
        logic [7:0]  le;
        logic [7:0]  be;
        mask = ((16'd1 << (4'd1 << size)) - 16'd1) << off;
        le   = mask[7:0];
        be   = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(lanes)) be[i] = le[3'(int'(lanes) - 1 - i)];
        end
        return big_endian ? be : le;
    endfunction

    function automatic logic [63:0] extend(input logic [63:0] data,
                                           input logic [1:0]  size,
                                           input logic        is_unsigned);
        case (size)
            SZ_B:    return {{56{~is_unsigned & data[7]}},  data[7:0]};
            SZ_H:    return {{48{~is_unsigned & data[15]}}, data[15:0]};
            SZ_W:    return {{32{~is_unsigned & data[31]}}, data[31:0]};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data path: moves the addressed bytes down to bit 0 and
// zero/sign-extends them according to the access size.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter bit          BIG_ENDIAN = 1'b0,
    localparam int unsigned LANES     = DATA_W / 8,
    localparam int unsigned OFF_W     = $clog2(LANES)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [OFF_W-1:0]  off,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] rdata_c
);

    int unsigned       nbytes;
    int unsigned       lane_sh;
    logic [DATA_W-1:0] shifted;

    // Big-endian values sit with their first byte in the highest lane of the field.
    always_comb begin
        nbytes  = 32'd1 << size;
        lane_sh = 32'(off);
        if (BIG_ENDIAN) begin
            lane_sh = (LANES >= 32'(off) + nbytes) ? LANES - 32'(off) - nbytes : 32'd0;
        end
        shifted = data >> (lane_sh * 32'd8);
        rdata_c = DATA_W'(extend(64'(shifted), size, is_unsigned));
    end

endmodule

// File: rtl/lsu_bus_adapter.sv
// MEM-stage load/store adapter: decodes the access, checks alignment, runs the
// req/addr_ok/data_ok bus handshake and returns aligned, extended load data.
module lsu_bus_adapter
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter bit          BIG_ENDIAN = 1'b0,
    localparam int unsigned LANES     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              flush,
    output logic              stall,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_exc,
    output logic [ADDR_W-1:0] resp_badvaddr,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [LANES-1:0]  bus_wstrb,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam int unsigned OFF_W = $clog2(LANES);

    lsu_state_e        state;
    logic [OFF_W-1:0]  off_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic [ADDR_W-1:0] addr_q;

    logic              accept_c;
    logic              misaligned_c;
    logic [LANES-1:0]  strobe_c;
    logic [DATA_W-1:0] wdata_rep_c;
    logic [DATA_W-1:0] load_data_c;
    int unsigned       rep_mask;

    assign req_ready = (state == ST_IDLE);
    assign stall     = (state != ST_IDLE) || (req_valid && req_ready);
    // A same-cycle flush wins over a new request.
    assign accept_c  = req_valid && req_ready && !flush;

    always_comb begin
        misaligned_c = 1'b0;
        case (req_size)
            SZ_B:    misaligned_c = 1'b0;
            SZ_H:    misaligned_c = req_addr[0];
            SZ_W:    misaligned_c = (req_addr[1:0] != 2'b00);
            default: misaligned_c = (req_addr[2:0] != 3'b000) || (DATA_W < 64);
        endcase
    end

    assign strobe_c = LANES'(mk_strobe(req_size, 3'(req_addr[OFF_W-1:0]),
                                       BIG_ENDIAN, 4'(LANES)));

    // Replicate the right-aligned store bytes across every lane.
    always_comb begin
        rep_mask    = (32'd1 << req_size) - 32'd1;
        wdata_rep_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            wdata_rep_c[i*8 +: 8] = req_wdata[(i & rep_mask)*8 +: 8];
        end
    end

    lsu_load_align #(
        .DATA_W     (DATA_W),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_load_align (
        .data        (bus_rdata),
        .off         (off_q),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .rdata_c     (load_data_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            off_q         <= '0;
            size_q        <= '0;
            unsigned_q    <= 1'b0;
            addr_q        <= '0;
            resp_valid    <= 1'b0;
            resp_exc      <= 1'b0;
            resp_rdata    <= '0;
            resp_badvaddr <= '0;
            bus_req       <= 1'b0;
            bus_wr        <= 1'b0;
            bus_wstrb     <= '0;
            bus_addr      <= '0;
            bus_wdata     <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_exc   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        off_q      <= req_addr[OFF_W-1:0];
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        addr_q     <= req_addr;
                        if (misaligned_c) begin
                            state <= ST_EXC;
                        end else begin
                            state     <= ST_ADDR;
                            bus_req   <= 1'b1;
                            bus_wr    <= req_we;
                            bus_wstrb <= strobe_c;
                            bus_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            bus_wdata <= wdata_rep_c;
                        end
                    end
                end
                ST_ADDR: begin
                    if (bus_addr_ok) begin
                        bus_req <= 1'b0;
                        if (bus_data_ok) begin
                            state <= ST_IDLE;
                            if (!flush) begin
                                resp_valid <= 1'b1;
                                resp_rdata <= load_data_c;
                            end
                        end else begin
                            // Address already taken by the bus: its data must still be drained.
                            state <= flush ? ST_DRAIN : ST_DATA;
                        end
                    end else if (flush) begin
                        bus_req <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (bus_data_ok) begin
                        state <= ST_IDLE;
                        if (!flush) begin
                            resp_valid <= 1'b1;
                            resp_rdata <= load_data_c;
                        end
                    end else if (flush) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (bus_data_ok) state <= ST_IDLE;
                end
                ST_EXC: begin
                    state <= ST_IDLE;
                    if (!flush) begin
                        resp_valid    <= 1'b1;
                        resp_exc      <= 1'b1;
                        resp_badvaddr <= addr_q;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_adapter.sv
// Directed bench for lsu_bus_adapter: three instances (32-bit LE, 32-bit BE,
// 64-bit LE) driven in lockstep from shared stimulus.
module tb_lsu_bus_adapter;

    logic        clk;
    logic        rst;
    logic        req_valid, req_we, req_unsigned, flush;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [63:0] bus_rdata;

    logic        le_req_ready, le_stall, le_resp_valid, le_resp_exc, le_bus_req, le_bus_wr;
    logic [31:0] le_resp_rdata, le_resp_badvaddr, le_bus_addr, le_bus_wdata;
    logic [3:0]  le_bus_wstrb;

    logic        be_req_ready, be_stall, be_resp_valid, be_resp_exc, be_bus_req, be_bus_wr;
    logic [31:0] be_resp_rdata, be_resp_badvaddr, be_bus_addr, be_bus_wdata;
    logic [3:0]  be_bus_wstrb;

    logic        c_req_ready, c_stall, c_resp_valid, c_resp_exc, c_bus_req, c_bus_wr;
    logic [63:0] c_resp_rdata, c_bus_wdata;
    logic [31:0] c_resp_badvaddr, c_bus_addr;
    logic [7:0]  c_bus_wstrb;

    int checks;
    int errors;

    lsu_bus_adapter #(.DATA_W(32), .ADDR_W(32), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(le_req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .flush(flush), .stall(le_stall),
        .resp_valid(le_resp_valid), .resp_rdata(le_resp_rdata), .resp_exc(le_resp_exc),
        .resp_badvaddr(le_resp_badvaddr), .bus_req(le_bus_req), .bus_wr(le_bus_wr),
        .bus_wstrb(le_bus_wstrb), .bus_addr(le_bus_addr), .bus_wdata(le_bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata[31:0])
    );

    lsu_bus_adapter #(.DATA_W(32), .ADDR_W(32), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(be_req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .flush(flush), .stall(be_stall),
        .resp_valid(be_resp_valid), .resp_rdata(be_resp_rdata), .resp_exc(be_resp_exc),
        .resp_badvaddr(be_resp_badvaddr), .bus_req(be_bus_req), .bus_wr(be_bus_wr),
        .bus_wstrb(be_bus_wstrb), .bus_addr(be_bus_addr), .bus_wdata(be_bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata[31:0])
    );

    lsu_bus_adapter #(.DATA_W(64), .ADDR_W(32), .BIG_ENDIAN(1'b0)) dut_64 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(c_req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush), .stall(c_stall),
        .resp_valid(c_resp_valid), .resp_rdata(c_resp_rdata), .resp_exc(c_resp_exc),
        .resp_badvaddr(c_resp_badvaddr), .bus_req(c_bus_req), .bus_wr(c_bus_wr),
        .bus_wstrb(c_bus_wstrb), .bus_addr(c_bus_addr), .bus_wdata(c_bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are then driven and
    // outputs checked one more time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 0; req_we = 0; req_size = 2'd0; req_unsigned = 0;
        req_addr = '0; req_wdata = '0; flush = 0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        repeat (2) step();
        #1;
        checks++; if (le_bus_req !== 1'b0) begin errors++; $display("FAIL rst_bus_req got %h exp 0", le_bus_req); end
        checks++; if (le_resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %h exp 0", le_resp_valid); end
        checks++; if (le_resp_exc !== 1'b0) begin errors++; $display("FAIL rst_resp_exc got %h exp 0", le_resp_exc); end
        checks++; if (le_bus_wstrb !== 4'h0) begin errors++; $display("FAIL rst_wstrb got %h exp 0", le_bus_wstrb); end
        checks++; if (le_bus_addr !== 32'h0) begin errors++; $display("FAIL rst_bus_addr got %h exp 0", le_bus_addr); end
        checks++; if (le_resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", le_resp_rdata); end
        checks++; if (le_req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %h exp 1", le_req_ready); end
        checks++; if (le_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %h exp 0", le_stall); end
        rst = 0;
    endtask

    task automatic test_load_byte();
        step();
        req_valid = 1; req_we = 0; req_size = 2'd0; req_unsigned = 0; req_addr = 32'h1003;
        bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 64'h0000_0000_80FF_1234;
        #1;
        checks++; if (le_stall !== 1'b1) begin errors++; $display("FAIL lb_c0_stall got %h exp 1", le_stall); end
        step();
        req_valid = 0;
        #1;
        checks++; if (le_bus_req !== 1'b1) begin errors++; $display("FAIL lb_bus_req got %h exp 1", le_bus_req); end
        checks++; if (le_bus_wstrb !== 4'b1000) begin errors++; $display("FAIL lb_le_wstrb got %b exp 1000", le_bus_wstrb); end
        checks++; if (le_bus_addr !== 32'h1000) begin errors++; $display("FAIL lb_bus_addr got %h exp 1000", le_bus_addr); end
        checks++; if (le_resp_valid !== 1'b0) begin errors++; $display("FAIL lb_c1_resp_valid got %h exp 0", le_resp_valid); end
        checks++; if (be_bus_wstrb !== 4'b0001) begin errors++; $display("FAIL lb_be_wstrb got %b exp 0001", be_bus_wstrb); end
        checks++; if (c_bus_wstrb !== 8'h08) begin errors++; $display("FAIL lb_64_wstrb got %h exp 08", c_bus_wstrb); end
        step();
        #1;
        checks++; if (le_resp_valid !== 1'b1) begin errors++; $display("FAIL lb_resp_valid got %h exp 1", le_resp_valid); end
        checks++; if (le_resp_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_le_rdata got %h exp ffffff80", le_resp_rdata); end
        checks++; if (le_resp_exc !== 1'b0) begin errors++; $display("FAIL lb_resp_exc got %h exp 0", le_resp_exc); end
        checks++; if (le_stall !== 1'b0) begin errors++; $display("FAIL lb_c2_stall got %h exp 0", le_stall); end
        checks++; if (le_bus_req !== 1'b0) begin errors++; $display("FAIL lb_c2_bus_req got %h exp 0", le_bus_req); end
        checks++; if (be_resp_rdata !== 32'h0000_0034) begin errors++; $display("FAIL lb_be_rdata got %h exp 00000034", be_resp_rdata); end
        checks++; if (c_resp_rdata !== 64'hFFFF_FFFF_FFFF_FF80) begin errors++; $display("FAIL lb_64_rdata got %h exp ffffffffffffff80", c_resp_rdata); end
        idle_inputs();
    endtask

    task automatic test_store_half();
        step();
        req_valid = 1; req_we = 1; req_size = 2'd1; req_addr = 32'h2002; req_wdata = 64'h0000_ABCD;
        #1;
        step();
        req_valid = 0; bus_addr_ok = 1; bus_data_ok = 1;
        #1;
        checks++; if (be_bus_wstrb !== 4'b0011) begin errors++; $display("FAIL sh_be_wstrb got %b exp 0011", be_bus_wstrb); end
        checks++; if (be_bus_wdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_be_wdata got %h exp abcdabcd", be_bus_wdata); end
        checks++; if (be_bus_addr !== 32'h2000) begin errors++; $display("FAIL sh_be_addr got %h exp 2000", be_bus_addr); end
        checks++; if (be_bus_wr !== 1'b1) begin errors++; $display("FAIL sh_be_wr got %h exp 1", be_bus_wr); end
        checks++; if (le_bus_wstrb !== 4'b1100) begin errors++; $display("FAIL sh_le_wstrb got %b exp 1100", le_bus_wstrb); end
        checks++; if (c_bus_wdata !== 64'hABCD_ABCD_ABCD_ABCD) begin errors++; $display("FAIL sh_64_wdata got %h exp abcdabcdabcdabcd", c_bus_wdata); end
        checks++; if (c_bus_wstrb !== 8'h0C) begin errors++; $display("FAIL sh_64_wstrb got %h exp 0c", c_bus_wstrb); end
        step();
        #1;
        checks++; if (be_resp_valid !== 1'b1) begin errors++; $display("FAIL sh_resp_valid got %h exp 1", be_resp_valid); end
        idle_inputs();
    endtask

    task automatic test_misaligned();
        step();
        req_valid = 1; req_we = 0; req_size = 2'd2; req_addr = 32'h3001;
        #1;
        step();
        req_valid = 0;
        #1;
        checks++; if (le_bus_req !== 1'b0) begin errors++; $display("FAIL mis_bus_req got %h exp 0", le_bus_req); end
        checks++; if (le_stall !== 1'b1) begin errors++; $display("FAIL mis_c1_stall got %h exp 1", le_stall); end
        checks++; if (le_resp_valid !== 1'b0) begin errors++; $display("FAIL mis_c1_resp_valid got %h exp 0", le_resp_valid); end
        step();
        #1;
        checks++; if (le_resp_valid !== 1'b1) begin errors++; $display("FAIL mis_resp_valid got %h exp 1", le_resp_valid); end
        checks++; if (le_resp_exc !== 1'b1) begin errors++; $display("FAIL mis_resp_exc got %h exp 1", le_resp_exc); end
        checks++; if (le_resp_badvaddr !== 32'h3001) begin errors++; $display("FAIL mis_badvaddr got %h exp 3001", le_resp_badvaddr); end
        checks++; if (le_stall !== 1'b0) begin errors++; $display("FAIL mis_c2_stall got %h exp 0", le_stall); end
        step();
        #1;
        checks++; if (le_resp_valid !== 1'b0) begin errors++; $display("FAIL mis_c3_resp_valid got %h exp 0", le_resp_valid); end
        idle_inputs();
    endtask

    task automatic test_wait_states();
        int   resp_count;
        logic exp_req, exp_stall;
        resp_count = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            step();
            req_valid = (cyc == 0); req_we = 0; req_size = 2'd2; req_unsigned = 1;
            req_addr = 32'h5000; bus_rdata = 64'h1234_5678;
            bus_addr_ok = (cyc == 4); bus_data_ok = (cyc == 6);
            #1;
            exp_req   = (cyc >= 1 && cyc <= 4);
            exp_stall = (cyc <= 6);
            checks++; if (le_bus_req !== exp_req) begin errors++; $display("FAIL ws_bus_req c%0d got %h exp %h", cyc, le_bus_req, exp_req); end
            checks++; if (le_stall !== exp_stall) begin errors++; $display("FAIL ws_stall c%0d got %h exp %h", cyc, le_stall, exp_stall); end
            if (exp_req) begin
                checks++; if (le_bus_addr !== 32'h5000) begin errors++; $display("FAIL ws_bus_addr c%0d got %h exp 5000", cyc, le_bus_addr); end
            end
            if (le_resp_valid === 1'b1) resp_count++;
            if (cyc == 7) begin
                checks++; if (le_resp_rdata !== 32'h1234_5678) begin errors++; $display("FAIL ws_rdata got %h exp 12345678", le_resp_rdata); end
            end
        end
        checks++; if (resp_count !== 1) begin errors++; $display("FAIL ws_resp_count got %0d exp 1", resp_count); end
        idle_inputs();
    endtask

    task automatic test_flush_data();
        logic exp_rv, exp_rdy;
        for (int cyc = 0; cyc < 9; cyc++) begin
            step();
            req_valid = (cyc == 0 || cyc == 6); req_we = 0; req_unsigned = 1;
            req_size = (cyc == 6) ? 2'd0 : 2'd2;
            req_addr = (cyc == 6) ? 32'h7001 : 32'h6000;
            flush = (cyc == 2);
            bus_addr_ok = (cyc == 1 || cyc == 7);
            bus_data_ok = (cyc == 5 || cyc == 7);
            bus_rdata = 64'h0000_9900;
            #1;
            exp_rv  = (cyc == 8);
            exp_rdy = (cyc == 0 || cyc == 6 || cyc == 8);
            checks++; if (le_resp_valid !== exp_rv) begin errors++; $display("FAIL fl_resp_valid c%0d got %h exp %h", cyc, le_resp_valid, exp_rv); end
            checks++; if (le_req_ready !== exp_rdy) begin errors++; $display("FAIL fl_req_ready c%0d got %h exp %h", cyc, le_req_ready, exp_rdy); end
            if (cyc == 7) begin
                checks++; if (le_bus_addr !== 32'h7000) begin errors++; $display("FAIL fl_bus_addr got %h exp 7000", le_bus_addr); end
                checks++; if (le_bus_wstrb !== 4'b0010) begin errors++; $display("FAIL fl_wstrb got %b exp 0010", le_bus_wstrb); end
            end
            if (cyc == 8) begin
                checks++; if (le_resp_rdata !== 32'h0000_0099) begin errors++; $display("FAIL fl_rdata got %h exp 00000099", le_resp_rdata); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_wide_word();
        logic [63:0] exp64;
        for (int s = 0; s < 2; s++) begin
            exp64 = (s == 0) ? 64'h0000_0000_DEAD_BEEF : 64'hFFFF_FFFF_DEAD_BEEF;
            step();
            req_valid = 1; req_we = 0; req_size = 2'd2; req_unsigned = (s == 0); req_addr = 32'h4004;
            #1;
            step();
            req_valid = 0; bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 64'hDEAD_BEEF_0000_0001;
            #1;
            checks++; if (c_bus_wstrb !== 8'hF0) begin errors++; $display("FAIL ww_64_wstrb got %h exp f0", c_bus_wstrb); end
            checks++; if (c_bus_addr !== 32'h4000) begin errors++; $display("FAIL ww_64_addr got %h exp 4000", c_bus_addr); end
            checks++; if (le_bus_wstrb !== 4'hF) begin errors++; $display("FAIL ww_le_wstrb got %h exp f", le_bus_wstrb); end
            step();
            #1;
            checks++; if (c_resp_rdata !== exp64) begin errors++; $display("FAIL ww_64_rdata s%0d got %h exp %h", s, c_resp_rdata, exp64); end
            checks++; if (le_resp_rdata !== 32'h0000_0001) begin errors++; $display("FAIL ww_le_rdata got %h exp 00000001", le_resp_rdata); end
            idle_inputs();
        end
    endtask

    task automatic test_dword();
        step();
        req_valid = 1; req_we = 0; req_size = 2'd3; req_addr = 32'h8008;
        #1;
        step();
        req_valid = 0; bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 64'h0123_4567_89AB_CDEF;
        #1;
        checks++; if (c_bus_req !== 1'b1) begin errors++; $display("FAIL dw_64_bus_req got %h exp 1", c_bus_req); end
        checks++; if (c_bus_wstrb !== 8'hFF) begin errors++; $display("FAIL dw_64_wstrb got %h exp ff", c_bus_wstrb); end
        checks++; if (le_bus_req !== 1'b0) begin errors++; $display("FAIL dw_le_bus_req got %h exp 0", le_bus_req); end
        step();
        #1;
        checks++; if (c_resp_rdata !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL dw_64_rdata got %h exp 0123456789abcdef", c_resp_rdata); end
        checks++; if (c_resp_exc !== 1'b0) begin errors++; $display("FAIL dw_64_exc got %h exp 0", c_resp_exc); end
        checks++; if (le_resp_exc !== 1'b1) begin errors++; $display("FAIL dw_le_exc got %h exp 1", le_resp_exc); end
        checks++; if (le_resp_badvaddr !== 32'h8008) begin errors++; $display("FAIL dw_le_badvaddr got %h exp 8008", le_resp_badvaddr); end
        idle_inputs();
    endtask

    task automatic test_flush_exc_priority();
        step();
        req_valid = 1; req_size = 2'd1; req_addr = 32'h9001;
        #1;
        step();
        req_valid = 0; flush = 1;
        #1;
        step();
        req_valid = 1; req_size = 2'd2; req_addr = 32'hA000; flush = 1;
        #1;
        checks++; if (le_resp_valid !== 1'b0) begin errors++; $display("FAIL fe_resp_valid got %h exp 0", le_resp_valid); end
        checks++; if (le_req_ready !== 1'b1) begin errors++; $display("FAIL fe_req_ready got %h exp 1", le_req_ready); end
        step();
        req_valid = 0; flush = 0;
        #1;
        checks++; if (le_bus_req !== 1'b0) begin errors++; $display("FAIL fp_bus_req got %h exp 0", le_bus_req); end
        checks++; if (le_req_ready !== 1'b1) begin errors++; $display("FAIL fp_req_ready got %h exp 1", le_req_ready); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        step();
        req_valid = 1; req_size = 2'd2; req_addr = 32'hB000;
        #1;
        step();
        req_valid = 0; rst = 1;
        #1;
        checks++; if (le_bus_req !== 1'b1) begin errors++; $display("FAIL rm_c1_bus_req got %h exp 1", le_bus_req); end
        step();
        rst = 0; bus_data_ok = 1;
        #1;
        checks++; if (le_bus_req !== 1'b0) begin errors++; $display("FAIL rm_bus_req got %h exp 0", le_bus_req); end
        checks++; if (le_req_ready !== 1'b1) begin errors++; $display("FAIL rm_req_ready got %h exp 1", le_req_ready); end
        for (int cyc = 0; cyc < 2; cyc++) begin
            step();
            #1;
            checks++; if (le_resp_valid !== 1'b0) begin errors++; $display("FAIL rm_resp_valid c%0d got %h exp 0", cyc, le_resp_valid); end
        end
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1;
        test_reset();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_wait_states();
        test_flush_data();
        test_wide_word();
        test_dword();
        test_flush_exc_priority();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
